// File: rtl/hash_capture.sv
// hash_capture: reassembles the byte-serial Blake2 digest from the registered
// hash byte bus into an on-chip buffer. It counts completed digests, flags
// short and overrun transfers, and offers a registered readback port for
// debug/ILA use.
//
// Optional feature: define HASH_CAPTURE_SIG_EN to keep an 8-bit running XOR
// of each digest and latch it into sig_o on completion. Without the macro,
// sig_o is tied to 0 and no XOR logic is built.

module hash_capture #(
  parameter int DIGEST_BYTES = 32,  // bytes per digest, 2..64
  parameter int CNT_W        = 16   // completed-digest counter width
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       hash_i,
  input  logic             hash_v_i,
  input  logic             clear_i,
  input  logic [5:0]       rd_addr_i,
  output logic [7:0]       rd_data_o,
  output logic             digest_valid_o,
  output logic             busy_o,
  output logic             err_short_o,
  output logic             err_over_o,
  output logic [CNT_W-1:0] digest_cnt_o,
  output logic [7:0]       sig_o
);

  // Buffer address width. This is at least 1 so the smallest legal digest
  // still has an address bit.
  localparam int         AW       = (DIGEST_BYTES > 1) ? $clog2(DIGEST_BYTES) : 1;
  localparam logic [5:0] LAST_IDX = 6'(DIGEST_BYTES - 1);
  localparam logic [6:0] DEPTH    = 7'(DIGEST_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE,
    ERROR
  } state_t;

  state_t     state;
  logic [5:0] idx;
  logic       hash_v_q;

  logic [7:0]    buf_mem [DIGEST_BYTES];
  logic          wr_en;
  logic [AW-1:0] wr_addr;

`ifdef HASH_CAPTURE_SIG_EN
  logic [7:0] sig_acc;
`endif

  // Buffer write strobe. Writes are allowed only when the FSM accepts the
  // byte. Clear and a frozen enable both drop the byte.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and infers a latch.
    wr_en   = 1'b0;
    wr_addr = '0;
    if (ena && !clear_i && hash_v_i) begin
      case (state)
        IDLE:    wr_en = 1'b1;
        CAPTURE: begin
          wr_en   = 1'b1;
          wr_addr = idx[AW-1:0];
        end
        DONE:    wr_en = !hash_v_q;  // only a fresh digest, not an overrun
        default: wr_en = 1'b0;
      endcase
    end
  end

  // Digest buffer. This is a plain RAM-style array with a synchronous write.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset. digest_valid_o qualifies its contents,
    // and leaving it unreset allows it to map onto distributed/block RAM.
    if (wr_en) buf_mem[wr_addr] <= hash_i;
  end

  // Registered readback. An address past the digest reads as 0. A read of the
  // address being written in the same cycle returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_o <= '0;
    end else if ({1'b0, rd_addr_i} < DEPTH) begin
      rd_data_o <= buf_mem[rd_addr_i[AW-1:0]];
    end else begin
      rd_data_o <= '0;
    end
  end

  // Capture FSM with registered status outputs, the digest counter and the
  // optional signature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments, so every branch
      // below reads the values from before this edge.
      state          <= IDLE;
      idx            <= '0;
      hash_v_q       <= 1'b0;
      busy_o         <= 1'b0;
      digest_valid_o <= 1'b0;
      err_short_o    <= 1'b0;
      err_over_o     <= 1'b0;
      digest_cnt_o   <= '0;
`ifdef HASH_CAPTURE_SIG_EN
      sig_acc        <= '0;
      sig_o          <= '0;
`endif
    end else begin
      if (ena) hash_v_q <= hash_v_i;

      if (clear_i) begin
        // Re-arm the capture. The buffer and the digest count survive.
        state          <= IDLE;
        idx            <= '0;
        busy_o         <= 1'b0;
        digest_valid_o <= 1'b0;
        err_short_o    <= 1'b0;
        err_over_o     <= 1'b0;
`ifdef HASH_CAPTURE_SIG_EN
        sig_o          <= '0;
`endif
      end else if (ena) begin
        case (state)
          IDLE: begin
            if (hash_v_i) begin
              state  <= CAPTURE;
              idx    <= 6'd1;
              busy_o <= 1'b1;
`ifdef HASH_CAPTURE_SIG_EN
              sig_acc <= hash_i;
`endif
            end
          end

          CAPTURE: begin
            if (hash_v_i) begin
              idx <= idx + 6'd1;
              if (idx == LAST_IDX) begin
                state          <= DONE;
                busy_o         <= 1'b0;
                digest_valid_o <= 1'b1;
                digest_cnt_o   <= digest_cnt_o + CNT_W'(1);
`ifdef HASH_CAPTURE_SIG_EN
                sig_o          <= sig_acc ^ hash_i;
`endif
              end
`ifdef HASH_CAPTURE_SIG_EN
              sig_acc <= sig_acc ^ hash_i;
`endif
            end else begin
              state       <= ERROR;
              busy_o      <= 1'b0;
              err_short_o <= 1'b1;
            end
          end

          DONE: begin
            if (hash_v_i) begin
              if (hash_v_q) begin
                // Valid did not drop after the last byte. Keep the digest
                // and flag the overrun.
                state      <= ERROR;
                err_over_o <= 1'b1;
              end else begin
                state          <= CAPTURE;
                idx            <= 6'd1;
                busy_o         <= 1'b1;
                digest_valid_o <= 1'b0;
`ifdef HASH_CAPTURE_SIG_EN
                sig_acc        <= hash_i;
`endif
              end
            end
          end

          ERROR: begin
            // Parked until clear_i.
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef HASH_CAPTURE_SIG_EN
  assign sig_o = '0;
`endif

endmodule

// File: tb/tb_hash_capture.sv
// Self-checking bench for hash_capture (DIGEST_BYTES=32). It combines a
// table-driven section for readback, enable freeze, short error and clear
// with hand-written sequences for overrun, back-to-back digests, enable
// pause and mid-capture reset.

module tb_hash_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  hash_i = '0;
  logic        hash_v_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [5:0]  rd_addr_i = '0;
  logic [7:0]  rd_data_o;
  logic        digest_valid_o;
  logic        busy_o;
  logic        err_short_o;
  logic        err_over_o;
  logic [15:0] digest_cnt_o;
  logic [7:0]  sig_o;

  int total = 0;
  int bad   = 0;

  hash_capture #(.DIGEST_BYTES(32), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ena            (ena),
    .hash_i         (hash_i),
    .hash_v_i       (hash_v_i),
    .clear_i        (clear_i),
    .rd_addr_i      (rd_addr_i),
    .rd_data_o      (rd_data_o),
    .digest_valid_o (digest_valid_o),
    .busy_o         (busy_o),
    .err_short_o    (err_short_o),
    .err_over_o     (err_over_o),
    .digest_cnt_o   (digest_cnt_o),
    .sig_o          (sig_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic        hv;
    logic        clr;
    logic [7:0]  hash;
    logic [5:0]  addr;
    logic        dv;
    logic        busy;
    logic        es;
    logic        eo;
    logic [15:0] cnt;
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic e, input logic hv, input logic cl,
                     input logic [7:0] h, input logic [5:0] a);
    ena       = e;
    hash_v_i  = hv;
    clear_i   = cl;
    hash_i    = h;
    rd_addr_i = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic dv, input logic busy,
                             input logic es, input logic eo, input logic [15:0] cnt);
    check({tag, ".valid"}, digest_valid_o, dv);
    check({tag, ".busy"},  busy_o,         busy);
    check({tag, ".short"}, err_short_o,    es);
    check({tag, ".over"},  err_over_o,     eo);
    check({tag, ".cnt"},   digest_cnt_o,   cnt);
  endtask

  task automatic check_all_zero(input string tag);
    check_flags(tag, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    check({tag, ".rd"},  rd_data_o, 8'h00);
    check({tag, ".sig"}, sig_o,     8'h00);
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_sig;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Digest A: bytes 0x00..0x1F
    for (int i = 0; i < 32; i++) begin
      cyc(1, 1, 0, 8'(i), 6'd0);
      if (i == 0)  check_flags("a_first", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      if (i == 30) check_flags("a_penult", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    end
    check_flags("a_done", 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    check("a_sig", sig_o, 8'h00);  // XOR of 0x00..0x1F is 0
    cyc(1, 0, 0, 8'h00, 6'd0);

    // Table: readback, enable freeze, short capture, error parking, clear
    //           ena hv clr hash   addr   dv busy es eo cnt    rd
    vecs[0]  = '{1, 0, 0, 8'h00, 6'd0,  1, 0, 0, 0, 16'd1, 8'h00};
    vecs[1]  = '{1, 0, 0, 8'h00, 6'd5,  1, 0, 0, 0, 16'd1, 8'h05};
    vecs[2]  = '{1, 0, 0, 8'h00, 6'd31, 1, 0, 0, 0, 16'd1, 8'h1F};
    vecs[3]  = '{1, 0, 0, 8'h00, 6'd32, 1, 0, 0, 0, 16'd1, 8'h00};
    vecs[4]  = '{1, 0, 0, 8'h00, 6'd63, 1, 0, 0, 0, 16'd1, 8'h00};
    vecs[5]  = '{0, 1, 0, 8'hEE, 6'd1,  1, 0, 0, 0, 16'd1, 8'h01};
    vecs[6]  = '{1, 0, 0, 8'h00, 6'd0,  1, 0, 0, 0, 16'd1, 8'h00};
    vecs[7]  = '{1, 1, 0, 8'h80, 6'd0,  0, 1, 0, 0, 16'd1, 8'h00};
    vecs[8]  = '{1, 1, 0, 8'h81, 6'd0,  0, 1, 0, 0, 16'd1, 8'h80};
    vecs[9]  = '{1, 0, 0, 8'h00, 6'd1,  0, 0, 1, 0, 16'd1, 8'h81};
    vecs[10] = '{1, 1, 0, 8'h99, 6'd2,  0, 0, 1, 0, 16'd1, 8'h02};
    vecs[11] = '{1, 0, 0, 8'h00, 6'd2,  0, 0, 1, 0, 16'd1, 8'h02};
    vecs[12] = '{1, 0, 1, 8'h00, 6'd0,  0, 0, 0, 0, 16'd1, 8'h80};
    for (int v = 0; v < 13; v++) begin
      cyc(vecs[v].ena, vecs[v].hv, vecs[v].clr, vecs[v].hash, vecs[v].addr);
      check_flags($sformatf("vec%0d", v), vecs[v].dv, vecs[v].busy,
                  vecs[v].es, vecs[v].eo, vecs[v].cnt);
      check($sformatf("vec%0d.rd", v), rd_data_o, vecs[v].rd);
    end

    // Overrun: 33 contiguous bytes 0x40..0x60
    for (int i = 0; i < 33; i++) begin
      cyc(1, 1, 0, 8'(8'h40 + i), 6'd0);
      if (i == 31) check_flags("ov_done", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    end
    check_flags("ov_err", 1'b1, 1'b0, 1'b0, 1'b1, 16'd2);
    // The clear wins over a simultaneous valid byte, which is dropped.
    cyc(1, 1, 1, 8'h77, 6'd0);
    check_flags("ov_clr", 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    cyc(1, 0, 0, 8'h00, 6'd0);
    check("ov_rd0", rd_data_o, 8'h40);
    cyc(1, 0, 0, 8'h00, 6'd31);
    check("ov_rd31", rd_data_o, 8'h5F);

    // Back-to-back digests with one idle cycle: 0xA5 then 0x5A
    for (int i = 0; i < 32; i++) cyc(1, 1, 0, 8'hA5, 6'd0);
    cyc(1, 0, 0, 8'h00, 6'd0);
    for (int i = 0; i < 32; i++) begin
      cyc(1, 1, 0, 8'h5A, 6'd0);
      if (i == 0) check_flags("b2b_start", 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
    end
    check_flags("b2b_done", 1'b1, 1'b0, 1'b0, 1'b0, 16'd4);
    cyc(1, 0, 0, 8'h00, 6'd0);
    for (int a = 0; a < 32; a++) begin
      cyc(1, 0, 0, 8'h00, 6'(a));
      check($sformatf("b2b_rd%0d", a), rd_data_o, 8'h5A);
    end

    // Enable pause mid-capture, with valid forced high
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, pat(i), 6'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 8'hFF, 6'd0);
      check_flags($sformatf("pause%0d", k), 1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
    end
    for (int i = 10; i < 32; i++) cyc(1, 1, 0, pat(i), 6'd0);
    check_flags("pause_done", 1'b1, 1'b0, 1'b0, 1'b0, 16'd5);
    exp_sig = 8'h00;
`ifdef HASH_CAPTURE_SIG_EN
    for (int i = 0; i < 32; i++) exp_sig = exp_sig ^ pat(i);
`endif
    check("pause_sig", sig_o, exp_sig);
    cyc(1, 0, 0, 8'h00, 6'd0);
    for (int a = 0; a < 32; a++) begin
      cyc(1, 0, 0, 8'h00, 6'(a));
      check($sformatf("pause_rd%0d", a), rd_data_o, pat(a));
    end
    // A clear still acts while the enable is low.
    cyc(0, 0, 1, 8'h00, 6'd0);
    check_flags("clr_ena0", 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
    check("clr_ena0.sig", sig_o, 8'h00);

    // Asynchronous reset during byte 15 of a capture
    for (int i = 0; i < 15; i++) cyc(1, 1, 0, 8'(8'h30 + i), 6'd0);
    check("pre_rst.busy", busy_o, 1'b1);
    ena = 1'b1; hash_v_i = 1'b1; hash_i = 8'h3F;
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(posedge clk);
    #1 check_all_zero("rst_hold");
    hash_v_i = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 32; i++) cyc(1, 1, 0, 8'(8'h20 + i), 6'd0);
    check_flags("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    check("post_rst.sig", sig_o, 8'h00);  // XOR of 0x20..0x3F is 0
    cyc(1, 0, 0, 8'h00, 6'd0);
    cyc(1, 0, 0, 8'h00, 6'd15);
    check("post_rst.rd15", rd_data_o, 8'h2F);
    cyc(1, 0, 0, 8'h00, 6'd31);
    check("post_rst.rd31", rd_data_o, 8'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hash_capture.md
# hash_capture

Downstream consumer of the Blake2 core's output bus inside the Basys3 emulator. Sits on the registered hash byte bus (`uo_out`) and the `hash_v` control line (`uio_out[7]`). Reassembles the byte-serial digest into an on-chip buffer, counts completed digests and flags protocol violations. Allows the FPGA to self-check hashes independently of the Raspberry Pi PIO reader, with a synchronous readback port for debug and ILA use.

## Interface
Parameters:
- `DIGEST_BYTES`, 32: bytes per digest. Legal range is 2..64.
- `CNT_W`, 16: width of the completed-digest counter.

Ports:
- `clk`  in  1  system clock, the PLL/BUFG clock of the emulator
- `rst_n`  in  1  reset. Asynchronous, active-low.
- `ena`  in  1  capture enable. Low freezes the FSM and ignores `hash_v_i`.
- `hash_i`  in  8  digest byte, sampled when `hash_v_i`=1
- `hash_v_i`  in  1  byte valid. One byte per cycle while high.
- `clear_i`  in  1  single-cycle pulse. Re-arms the capture and clears the flags.
- `rd_addr_i`  in  6  readback byte index
- `rd_data_o`  out  8  readback byte, registered
- `digest_valid_o`  out  1  a complete digest is held in the buffer
- `busy_o`  out  1  capture in progress
- `err_short_o`  out  1  `hash_v_i` dropped before `DIGEST_BYTES` bytes were received
- `err_over_o`  out  1  `hash_v_i` stayed high past the last byte
- `digest_cnt_o`  out  CNT_W  number of completed digests, wraps
- `sig_o`  out  8  XOR signature of the last digest (see Configuration)

## Operation
- FSM states: IDLE, CAPTURE, DONE, ERROR. Byte index `idx` is a 6-bit register. A `hash_v_q` register holds the previous cycle's `hash_v_i`.
- IDLE:
  - `hash_v_i`=1 writes `buf[0]`, sets `idx`=1 and moves to CAPTURE.
- CAPTURE:
  - `hash_v_i`=1 writes `buf[idx]` and increments `idx`.
  - On the write with `idx`=`DIGEST_BYTES`-1: move to DONE, set `digest_valid_o`=1, increment `digest_cnt_o` (wraps).
  - `hash_v_i`=0 moves to ERROR and sets `err_short_o`=1.
- DONE:
  - `hash_v_i`=1 with `hash_v_q`=1 (contiguous overrun) moves to ERROR, sets `err_over_o`=1, and keeps `digest_valid_o` and the buffer intact.
  - `hash_v_i`=1 with `hash_v_q`=0 starts a new digest: clears `digest_valid_o`, writes `buf[0]`, sets `idx`=1, moves to CAPTURE.
- ERROR: stays in ERROR until `clear_i`. No writes are performed.
- `clear_i` in any state:
  - Next state is IDLE; clears `idx`, `err_short_o`, `err_over_o`, `digest_valid_o` and `sig_o`.
  - The buffer and `digest_cnt_o` are kept.
  - `clear_i` has priority over `hash_v_i` in the same cycle, and that byte is dropped.
- `ena`=0: state, `idx`, `hash_v_q` and the buffer hold. Readback and `clear_i` still work.
- `busy_o`=1 exactly while in CAPTURE.
- Readback: `rd_data_o` <= `buf[rd_addr_i]` every cycle. Returns 0 when `rd_addr_i` >= `DIGEST_BYTES`. A read of the address being written in the same cycle returns the old value.

## Timing
- Reset values: state IDLE, `idx`=0, `hash_v_q`=0, and every output 0. The buffer is not reset.
- Capture has zero-cycle input latency: the byte is written on the rising edge where `hash_v_i`=1.
- `digest_valid_o`, `digest_cnt_o` and `sig_o` update on the edge that writes the last byte. They are visible the following cycle.
- Error flags rise on the edge where the violation is sampled.
- Readback latency is 1 cycle.
- A `rst_n` assertion mid-capture returns to the reset values immediately (asynchronously). No partial-digest flag is raised.
- Back-to-back digests need at least one `hash_v_i`=0 cycle between them. Zero gap is `err_over_o`.

## Configuration
- `HASH_CAPTURE_SIG_EN` defined:
  - An 8-bit running XOR of every captured byte is kept. It resets at the start of each digest.
  - It is latched into `sig_o` on completion and shown on the debug LEDs.
- `HASH_CAPTURE_SIG_EN` undefined: `sig_o` is tied to 0 and no XOR logic is built.

## Test plan
- Reset, then `hash_v_i` high for 32 cycles with bytes 0x00..0x1F.
  - Required: `digest_valid_o`=1 one cycle after the last byte, and `digest_cnt_o`=1.
  - Readback at addresses 0..31 returns 0x00..0x1F with 1-cycle latency.
  - With `HASH_CAPTURE_SIG_EN`: `sig_o`=0x00.
- `hash_v_i` high for 10 cycles, then low.
  - Required: `err_short_o`=1, `busy_o`=0, state ERROR.
  - A `clear_i` pulse returns all flags to 0 with `digest_cnt_o` unchanged.
- `hash_v_i` high for 33 cycles.
  - Required: `err_over_o`=1, `digest_valid_o` stays 1, `digest_cnt_o`=1, and the buffer holds the first 32 bytes.
- Two 32-byte digests separated by 1 idle cycle, all bytes 0xA5 then all bytes 0x5A.
  - Required: `digest_cnt_o`=2, readback shows 0x5A at every address, no error flag.
- `ena`=0 for 5 cycles mid-capture (`hash_v_i` forced high), then resumed.
  - Required: no bytes written while `ena`=0, and the capture completes normally after resume.
- `rst_n` low in the middle of byte 15 of a capture.
  - Required: all outputs read 0 while reset is asserted.
  - A subsequent full 32-byte digest completes with `digest_cnt_o`=1.
